// File: rtl/tower_game_pkg.sv
// Shared types for the stacking game engine: FSM states, status codes and
// slide direction.
package tower_game_pkg;

    typedef enum logic [1:0] {
        MOVE = 2'd0,
        EVAL = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    localparam logic [1:0] PLAYING = 2'b00;
    localparam logic [1:0] WON     = 2'b01;
    localparam logic [1:0] LOST    = 2'b10;

endpackage

// File: rtl/tower_overlap.sv
// Horizontal overlap between the active block and the block below it.
// All arithmetic is one bit wider than the coordinates so the right edges
// (left edge + width) cannot wrap.
module tower_overlap #(
    parameter int X_W = 8
) (
    input  logic [X_W-1:0] x,
    input  logic [X_W-1:0] width,
    input  logic [X_W-1:0] prev_x,
    input  logic [X_W-1:0] prev_w,
    output logic [X_W:0]   lo,
    output logic [X_W:0]   hi,
    output logic           hit
);

    logic [X_W:0] act_end;
    logic [X_W:0] prev_end;

    // Overlap is [max(left edges), min(right edges)); empty when hi <= lo.
    always_comb begin
        act_end  = {1'b0, x} + {1'b0, width};
        prev_end = {1'b0, prev_x} + {1'b0, prev_w};
        lo       = (x > prev_x) ? {1'b0, x} : {1'b0, prev_x};
        hi       = (act_end < prev_end) ? act_end : prev_end;
        hit      = (hi > lo);
    end

endmodule

// File: rtl/tower_game_core.sv
// Stacking game engine: slides the active block on frame ticks, evaluates
// the drop against the stacked block, trims the block to the overlap and
// tracks score, chances and win/lose status.
//
// Redraw strobe: w_o is a one-cycle pulse that follows every position or
// geometry change; the drawing side needs no acknowledge. A sync that lands
// while w_o is high (the cycle right after an evaluation) is dropped, which
// keeps w_o from ever being high on two consecutive cycles.
module tower_game_core
    import tower_game_pkg::*;
#(
    parameter int  SCREEN_W  = 160,
    parameter int  SCREEN_H  = 120,
    parameter int  BLK_W     = 20,
    parameter int  BLK_H     = 4,
    parameter int  STEP      = 1,
    parameter int  CHANCES   = 3,
    parameter int  SCORE_W   = 4,
    parameter int  WIN_SCORE = 15,
    localparam int X_W       = $clog2(SCREEN_W),
    localparam int Y_W       = $clog2(SCREEN_H),
    localparam int CH_W      = $clog2(CHANCES + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sync,
    input  logic               KEY,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [X_W-1:0]     width,
    output logic [X_W-1:0]     prev_x,
    output logic [SCORE_W-1:0] score,
    output logic [CH_W-1:0]    chances,
    output logic [1:0]         game_status,
    output logic               w_o,
    output logic [1:0]         state_dbg
);

    localparam int XE = X_W + 1;

    state_t             state;
    dir_t               dir;
    logic               key_q;
    logic [X_W-1:0]     prev_w;
    logic               drop;
    logic [X_W-1:0]     limit;
    logic [X_W:0]       nx_r;
    logic [SCORE_W-1:0] next_score;
    logic [X_W:0]       ov_lo;
    logic [X_W:0]       ov_hi;
    logic               ov_hit;

    assign state_dbg = state;

    tower_overlap #(.X_W(X_W)) u_overlap (
        .x      (x),
        .width  (width),
        .prev_x (prev_x),
        .prev_w (prev_w),
        .lo     (ov_lo),
        .hi     (ov_hi),
        .hit    (ov_hit)
    );

    // Drop edge, right-hand wall position, candidate step and saturating score.
    always_comb begin
        drop       = key_q & ~KEY;
        limit      = X_W'(SCREEN_W) - width;
        nx_r       = {1'b0, x} + XE'(STEP);
        next_score = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
    end

    // Game FSM with all outputs registered; terminal states hold everything.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= MOVE;
            dir         <= DIR_RIGHT;
            key_q       <= 1'b1;
            x           <= '0;
            y           <= Y_W'(SCREEN_H - 2 * BLK_H);
            width       <= X_W'(BLK_W);
            prev_x      <= X_W'((SCREEN_W - BLK_W) / 2);
            prev_w      <= X_W'(BLK_W);
            score       <= '0;
            chances     <= CH_W'(CHANCES);
            game_status <= PLAYING;
            w_o         <= 1'b0;
        end else begin
            key_q <= KEY;
            w_o   <= 1'b0;
            case (state)
                MOVE: begin
                    if (drop) begin
                        // A drop in the same cycle as sync wins; no move this frame.
                        state <= EVAL;
                    end else if (sync && !w_o) begin
                        w_o <= 1'b1;
                        // Direction flips as soon as the block touches a wall.
                        if (dir == DIR_RIGHT) begin
                            if (nx_r >= {1'b0, limit}) begin
                                x   <= limit;
                                dir <= DIR_LEFT;
                            end else begin
                                x <= nx_r[X_W-1:0];
                            end
                        end else begin
                            if ({1'b0, x} <= XE'(STEP)) begin
                                x   <= '0;
                                dir <= DIR_RIGHT;
                            end else begin
                                x <= x - X_W'(STEP);
                            end
                        end
                    end
                end
                EVAL: begin
                    w_o <= 1'b1;
                    if (ov_hit) begin
                        prev_x <= ov_lo[X_W-1:0];
                        prev_w <= X_W'(ov_hi - ov_lo);
                        width  <= X_W'(ov_hi - ov_lo);
                        score  <= next_score;
                        x      <= '0;
                        dir    <= DIR_RIGHT;
                        if (next_score == SCORE_W'(WIN_SCORE) || y < Y_W'(BLK_H)) begin
                            state       <= WIN;
                            game_status <= WON;
                        end else begin
                            y     <= y - Y_W'(BLK_H);
                            state <= MOVE;
                        end
                    end else begin
                        chances <= chances - CH_W'(1);
                        if (chances == CH_W'(1)) begin
                            state       <= LOSE;
                            game_status <= LOST;
                        end else begin
                            x     <= '0;
                            dir   <= DIR_RIGHT;
                            state <= MOVE;
                        end
                    end
                end
                WIN, LOSE: begin
                end
                default: state <= MOVE;
            endcase
        end
    end

endmodule

// File: tb/tb_tower_game_core.sv
module tb_tower_game_core;
    import tower_game_pkg::*;

    localparam int OP_SYNC = 0;
    localparam int OP_DROP = 1;
    localparam int OP_RST  = 2;

    typedef struct {
        int op;
        int n;
        int ex;
        int ey;
        int ew;
        int epx;
        int es;
        int ec;
        int est;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic sync;
    logic KEY;

    logic [7:0] a_x, a_width, a_prev_x, b_x, b_width, b_prev_x;
    logic [6:0] a_y, b_y;
    logic [3:0] a_score, b_score;
    logic [1:0] a_chances, b_chances, a_status, b_status, a_state, b_state;
    logic       a_w_o, b_w_o;

    tower_game_core dut_a (
        .clk(clk), .resetn(resetn), .sync(sync), .KEY(KEY),
        .x(a_x), .y(a_y), .width(a_width), .prev_x(a_prev_x),
        .score(a_score), .chances(a_chances), .game_status(a_status),
        .w_o(a_w_o), .state_dbg(a_state)
    );

    tower_game_core #(.WIN_SCORE(2)) dut_b (
        .clk(clk), .resetn(resetn), .sync(sync), .KEY(KEY),
        .x(b_x), .y(b_y), .width(b_width), .prev_x(b_prev_x),
        .score(b_score), .chances(b_chances), .game_status(b_status),
        .w_o(b_w_o), .state_dbg(b_state)
    );

    // scoreboard counters
    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int ex, input int ey, input int ew,
                         input int epx, input int es, input int ec, input int est);
        chk({tag, ".x"},       int'(a_x),       ex);
        chk({tag, ".y"},       int'(a_y),       ey);
        chk({tag, ".width"},   int'(a_width),   ew);
        chk({tag, ".prev_x"},  int'(a_prev_x),  epx);
        chk({tag, ".score"},   int'(a_score),   es);
        chk({tag, ".chances"}, int'(a_chances), ec);
        chk({tag, ".status"},  int'(a_status),  est);
    endtask

    task automatic chk_b(input string tag, input int ex, input int ey, input int ew,
                         input int epx, input int es, input int ec, input int est);
        chk({tag, ".x"},       int'(b_x),       ex);
        chk({tag, ".y"},       int'(b_y),       ey);
        chk({tag, ".width"},   int'(b_width),   ew);
        chk({tag, ".prev_x"},  int'(b_prev_x),  epx);
        chk({tag, ".score"},   int'(b_score),   es);
        chk({tag, ".chances"}, int'(b_chances), ec);
        chk({tag, ".status"},  int'(b_status),  est);
    endtask

    // driver tasks: inputs change on the falling edge, DUT samples on the rising edge
    task automatic do_reset();
        @(negedge clk) resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
    endtask

    task automatic do_sync(input int n);
        repeat (n) begin
            @(negedge clk) sync = 1'b1;
            @(negedge clk) sync = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_drop();
        @(negedge clk) KEY = 1'b0;
        @(negedge clk) KEY = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        sync   = 1'b0;
        KEY    = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // reset state
        chk_a("reset", 0, 112, 20, 70, 0, 3, 0);
        chk("reset.w_o", int'(a_w_o), 0);
        chk("reset.state", int'(a_state), int'(MOVE));

        // vector table: {op, count, x, y, width, prev_x, score, chances, status}
        vq.push_back('{OP_SYNC, 140, 140, 112, 20, 70, 0, 3, 0});
        vq.push_back('{OP_SYNC,   1, 139, 112, 20, 70, 0, 3, 0});
        vq.push_back('{OP_SYNC,  69,  70, 112, 20, 70, 0, 3, 0});
        vq.push_back('{OP_DROP,   1,   0, 108, 20, 70, 1, 3, 0});
        vq.push_back('{OP_RST,    1,   0, 112, 20, 70, 0, 3, 0});
        vq.push_back('{OP_SYNC,  80,  80, 112, 20, 70, 0, 3, 0});
        vq.push_back('{OP_DROP,   1,   0, 108, 10, 80, 1, 3, 0});
        vq.push_back('{OP_SYNC,  85,  85, 108, 10, 80, 1, 3, 0});
        vq.push_back('{OP_DROP,   1,   0, 104,  5, 85, 2, 3, 0});
        vq.push_back('{OP_SYNC,  10,  10, 104,  5, 85, 2, 3, 0});
        vq.push_back('{OP_DROP,   1,   0, 104,  5, 85, 2, 2, 0});
        vq.push_back('{OP_SYNC,  10,  10, 104,  5, 85, 2, 2, 0});
        vq.push_back('{OP_DROP,   1,   0, 104,  5, 85, 2, 1, 0});
        vq.push_back('{OP_SYNC,  10,  10, 104,  5, 85, 2, 1, 0});
        vq.push_back('{OP_DROP,   1,  10, 104,  5, 85, 2, 0, 2});
        vq.push_back('{OP_SYNC,   5,  10, 104,  5, 85, 2, 0, 2});
        vq.push_back('{OP_DROP,   1,  10, 104,  5, 85, 2, 0, 2});
        vq.push_back('{OP_RST,    1,   0, 112, 20, 70, 0, 3, 0});

        for (int i = 0; i < vq.size(); i++) begin
            case (vq[i].op)
                OP_SYNC: do_sync(vq[i].n);
                OP_DROP: do_drop();
                default: do_reset();
            endcase
            chk_a($sformatf("v%0d", i), vq[i].ex, vq[i].ey, vq[i].ew,
                  vq[i].epx, vq[i].es, vq[i].ec, vq[i].est);
        end

        // w_o is a single-cycle pulse one cycle after sync
        @(negedge clk) sync = 1'b1;
        @(negedge clk) sync = 1'b0;
        chk("strobe.w_o_high", int'(a_w_o), 1);
        chk("strobe.x", int'(a_x), 1);
        @(negedge clk);
        chk("strobe.w_o_low", int'(a_w_o), 0);

        // sync and drop together: drop wins, block evaluated at x=70 untouched
        do_reset();
        do_sync(70);
        @(negedge clk) begin sync = 1'b1; KEY = 1'b0; end
        @(negedge clk) begin sync = 1'b0; KEY = 1'b1; end
        @(negedge clk);
        @(negedge clk);
        chk_a("syncdrop", 0, 108, 20, 70, 1, 3, 0);

        // drop latency and sync during EVAL being discarded
        do_sync(70);
        @(negedge clk) KEY = 1'b0;
        @(negedge clk) begin KEY = 1'b1; sync = 1'b1; end
        chk("lat.state_eval", int'(a_state), int'(EVAL));
        chk("lat.w_o_eval", int'(a_w_o), 0);
        chk("lat.score_eval", int'(a_score), 1);
        @(negedge clk) sync = 1'b0;
        chk("lat.w_o_done", int'(a_w_o), 1);
        chk("lat.score_done", int'(a_score), 2);
        chk("lat.y_done", int'(a_y), 104);
        @(negedge clk);
        chk("lat.w_o_clear", int'(a_w_o), 0);
        chk("lat.x_nocatchup", int'(a_x), 0);

        // WIN_SCORE=2 instance: two perfect drops win and freeze
        do_reset();
        do_sync(70);
        do_drop();
        chk_b("win1", 0, 108, 20, 70, 1, 3, 0);
        do_sync(70);
        do_drop();
        chk_b("win2", 0, 108, 20, 70, 2, 3, 1);
        chk("win2.state", int'(b_state), int'(WIN));
        do_sync(4);
        do_drop();
        chk_b("winfrozen", 0, 108, 20, 70, 2, 3, 1);

        // reset asserted while EVAL is pending
        do_reset();
        do_sync(70);
        @(negedge clk) KEY = 1'b0;
        @(negedge clk) begin KEY = 1'b1; resetn = 1'b0; end
        chk("rsteval.state_eval", int'(b_state), int'(EVAL));
        @(negedge clk) resetn = 1'b1;
        chk_b("rsteval", 0, 112, 20, 70, 0, 3, 0);
        chk("rsteval.w_o", int'(b_w_o), 0);
        chk("rsteval.state", int'(b_state), int'(MOVE));
        @(negedge clk);
        chk("rsteval.w_o_after", int'(b_w_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
